// File: rtl/cdnsdru_usb4_message_bus_m2p_rx_v4_pkg.sv
// Shared definitions for the M2P message bus receiver: command codes, widths,
// the write-buffer entry layout and the shared status register addresses.
package cdnsdru_usb4_message_bus_m2p_rx_v4_pkg;

    localparam int unsigned MB_ADDR_W = 12;
    localparam int unsigned MB_DATA_W = 8;
    localparam int unsigned MB_CMD_W  = 4;

    localparam logic [MB_CMD_W-1:0] MB_CMD_NOP     = 4'h0;
    localparam logic [MB_CMD_W-1:0] MB_CMD_WR_UNC  = 4'h1;
    localparam logic [MB_CMD_W-1:0] MB_CMD_WR_COM  = 4'h2;
    localparam logic [MB_CMD_W-1:0] MB_CMD_READ    = 4'h3;
    localparam logic [MB_CMD_W-1:0] MB_CMD_RD_CPL  = 4'h4;
    localparam logic [MB_CMD_W-1:0] MB_CMD_WR_ACK  = 4'h5;

    // Status registers also targeted by the P2M write path
    localparam logic [MB_ADDR_W-1:0] MAC_TX_STAT_0 = 12'h400;
    localparam logic [MB_ADDR_W-1:0] MAC_TX_STAT_1 = 12'h401;
    localparam logic [MB_ADDR_W-1:0] MAC_RX_STAT_0 = 12'h402;
    localparam logic [MB_ADDR_W-1:0] MAC_RX_STAT_1 = 12'h403;

    typedef struct packed {
        logic                 commit;
        logic [MB_ADDR_W-1:0] addr;
        logic [MB_DATA_W-1:0] data;
    } mb_wr_entry_t;

    localparam int unsigned MB_ENTRY_W = $bits(mb_wr_entry_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_CPL
    } mb_rx_state_t;

endpackage

// File: rtl/cdnsdru_usb4_message_bus_m2p_rx_v4_wr_buf.sv
// Synchronous FIFO holding {commit, addr, data} write entries until a commit flushes them.
module cdnsdru_usb4_mb_wr_buf
    import cdnsdru_usb4_message_bus_m2p_rx_v4_pkg::*;
#(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [MB_ENTRY_W-1:0] push_entry,
    input  logic                  pop,
    output logic [MB_ENTRY_W-1:0] pop_entry,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [MB_ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign pop_entry = mem[rd_ptr];

    // Non-power-of-two depth, so pointers wrap explicitly
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cdnsdru_usb4_message_bus_m2p_rx_v4.sv
// M2P message bus receiver: parses MAC->PHY frames, buffers uncommitted writes and
// flushes them to the PHY register port when a committed write lands.
module cdnsdru_usb4_message_bus_m2p_rx_v4
    import cdnsdru_usb4_message_bus_m2p_rx_v4_pkg::*;
#(
    parameter int unsigned WBUF_DEPTH = 5
) (
    input  logic        pipe_mac2phy_clk,
    input  logic        pipe_mac2phy_rstn,
    input  logic [7:0]  m2p_messagebus,
    output logic        reg_wr_en,
    output logic [11:0] reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        m2p_rd_req,
    output logic [11:0] m2p_rd_addr,
    output logic        m2p_rd_cpl_valid,
    output logic [7:0]  m2p_rd_cpl_data,
    output logic        m2p_wr_ack,
    output logic        mb_tx_ack_req_toggle,
    output logic        mb_rx_err
);

    localparam int unsigned FIFO_DEPTH = WBUF_DEPTH + 1;
    localparam int unsigned CNT_W      = $clog2(WBUF_DEPTH + 2);

    logic clk;
    logic rst_n;
    assign clk   = pipe_mac2phy_clk;
    assign rst_n = pipe_mac2phy_rstn;

    mb_rx_state_t    state_q, state_d;
    logic [3:0]      addr_hi_q, addr_hi_d;
    logic [7:0]      addr_lo_q, addr_lo_d;
    logic            commit_q, commit_d;
    logic [3:0]      cmd;

    logic            push_c, err_c, rd_req_c, cpl_c, ack_c;
    logic            pop_c, pop_commit_c;
    logic            commit_pending_q;
    logic            ack_pend_q;

    mb_wr_entry_t    push_entry;
    mb_wr_entry_t    pop_entry;
    logic [MB_ENTRY_W-1:0] pop_raw;
    logic            fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] unc_count;

    assign cmd = m2p_messagebus[7:4];

    // At most one commit entry is ever buffered, and only while commit_pending is set
    assign unc_count = fifo_count - CNT_W'(commit_pending_q);

    assign push_entry = '{commit: commit_q, addr: {addr_hi_q, addr_lo_q}, data: m2p_messagebus};
    assign pop_entry  = mb_wr_entry_t'(pop_raw);

    assign pop_c        = commit_pending_q && !fifo_empty;
    assign pop_commit_c = pop_c && pop_entry.commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_hi_q <= '0;
            addr_lo_q <= '0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_hi_q <= addr_hi_d;
            addr_lo_q <= addr_lo_d;
            commit_q  <= commit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_hi_d = addr_hi_q;
        addr_lo_d = addr_lo_q;
        commit_d  = commit_q;
        push_c    = 1'b0;
        err_c     = 1'b0;
        rd_req_c  = 1'b0;
        cpl_c     = 1'b0;
        ack_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                case (cmd)
                    MB_CMD_NOP: ;
                    MB_CMD_WR_UNC, MB_CMD_WR_COM: begin
                        addr_hi_d = m2p_messagebus[3:0];
                        commit_d  = (cmd == MB_CMD_WR_COM);
                        state_d   = ST_WR_ADDR;
                    end
                    MB_CMD_READ: begin
                        addr_hi_d = m2p_messagebus[3:0];
                        state_d   = ST_RD_ADDR;
                    end
                    MB_CMD_RD_CPL: state_d = ST_RD_CPL;
                    MB_CMD_WR_ACK: ack_c   = 1'b1;
                    default:       err_c   = 1'b1;
                endcase
            end
            ST_WR_ADDR: begin
                addr_lo_d = m2p_messagebus;
                state_d   = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                state_d = ST_IDLE;
                if (commit_q ? commit_pending_q : (unc_count >= CNT_W'(WBUF_DEPTH))) begin
                    err_c = 1'b1;
                end else if (!fifo_full) begin
                    push_c = 1'b1;
                end else begin
                    err_c = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                addr_lo_d = m2p_messagebus;
                rd_req_c  = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RD_CPL: begin
                cpl_c   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    cdnsdru_usb4_mb_wr_buf #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_wr_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .push_entry (MB_ENTRY_W'(push_entry)),
        .pop        (pop_c),
        .pop_entry  (pop_raw),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Flush sequencer, ack toggle and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pending_q     <= 1'b0;
            ack_pend_q           <= 1'b0;
            reg_wr_en            <= 1'b0;
            reg_wr_addr          <= '0;
            reg_wr_data          <= '0;
            m2p_rd_req           <= 1'b0;
            m2p_rd_addr          <= '0;
            m2p_rd_cpl_valid     <= 1'b0;
            m2p_rd_cpl_data      <= '0;
            m2p_wr_ack           <= 1'b0;
            mb_tx_ack_req_toggle <= 1'b0;
            mb_rx_err            <= 1'b0;
        end else begin
            if (pop_commit_c) begin
                commit_pending_q <= 1'b0;
            end else if (push_c && commit_q) begin
                commit_pending_q <= 1'b1;
            end
            ack_pend_q <= pop_commit_c;
            if (ack_pend_q) begin
                mb_tx_ack_req_toggle <= ~mb_tx_ack_req_toggle;
            end
            reg_wr_en <= pop_c;
            if (pop_c) begin
                reg_wr_addr <= pop_entry.addr;
                reg_wr_data <= pop_entry.data;
            end
            m2p_rd_req <= rd_req_c;
            if (rd_req_c) begin
                m2p_rd_addr <= {addr_hi_q, m2p_messagebus};
            end
            m2p_rd_cpl_valid <= cpl_c;
            if (cpl_c) begin
                m2p_rd_cpl_data <= m2p_messagebus;
            end
            m2p_wr_ack <= ack_c;
            mb_rx_err  <= err_c;
        end
    end

endmodule

// File: tb/tb_cdnsdru_usb4_message_bus_m2p_rx_v4.sv
// Bench for the M2P message bus receiver: directed timing sequences, a frame table
// and a random frame stream checked against a frame-level reference model.
module tb_cdnsdru_usb4_message_bus_m2p_rx_v4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  mb = 8'h00;
    logic        reg_wr_en;
    logic [11:0] reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        m2p_rd_req;
    logic [11:0] m2p_rd_addr;
    logic        m2p_rd_cpl_valid;
    logic [7:0]  m2p_rd_cpl_data;
    logic        m2p_wr_ack;
    logic        mb_tx_ack_req_toggle;
    logic        mb_rx_err;

    always #5 clk = ~clk;

    cdnsdru_usb4_message_bus_m2p_rx_v4 #(.WBUF_DEPTH(5)) dut (
        .pipe_mac2phy_clk     (clk),
        .pipe_mac2phy_rstn    (rst_n),
        .m2p_messagebus       (mb),
        .reg_wr_en            (reg_wr_en),
        .reg_wr_addr          (reg_wr_addr),
        .reg_wr_data          (reg_wr_data),
        .m2p_rd_req           (m2p_rd_req),
        .m2p_rd_addr          (m2p_rd_addr),
        .m2p_rd_cpl_valid     (m2p_rd_cpl_valid),
        .m2p_rd_cpl_data      (m2p_rd_cpl_data),
        .m2p_wr_ack           (m2p_wr_ack),
        .mb_tx_ack_req_toggle (mb_tx_ack_req_toggle),
        .mb_rx_err            (mb_rx_err)
    );

    int pass_cnt = 0;
    int check_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Event monitor, sampled on the falling edge
    logic [19:0] wr_log[$];
    logic [11:0] rd_log[$];
    logic [7:0]  cpl_log[$];
    int ack_cnt = 0, err_cnt = 0, tog_cnt = 0;
    logic tog_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr_en)        wr_log.push_back({reg_wr_addr, reg_wr_data});
            if (m2p_rd_req)       rd_log.push_back(m2p_rd_addr);
            if (m2p_rd_cpl_valid) cpl_log.push_back(m2p_rd_cpl_data);
            if (m2p_wr_ack)       ack_cnt++;
            if (mb_rx_err)        err_cnt++;
            if (mb_tx_ack_req_toggle != tog_prev) tog_cnt++;
        end
        tog_prev = mb_tx_ack_req_toggle;
    end

    function automatic logic [63:0] all_outs();
        return 64'({reg_wr_en, reg_wr_addr, reg_wr_data, m2p_rd_req, m2p_rd_addr,
                    m2p_rd_cpl_valid, m2p_rd_cpl_data, m2p_wr_ack, mb_tx_ack_req_toggle, mb_rx_err});
    endfunction

    task automatic send(input logic [7:0] b);
        mb = b;
        @(posedge clk);
        #1;
        mb = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input bit commit, input logic [11:0] a, input logic [7:0] d);
        send({(commit ? 4'h2 : 4'h1), a[11:8]});
        send(a[7:0]);
        send(d);
    endtask

    task automatic rd(input logic [11:0] a);
        send({4'h3, a[11:8]});
        send(a[7:0]);
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          nb;
        int          exp_rd;
        int          exp_cpl;
        int          exp_ack;
        int          exp_err;
        logic [11:0] exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, w0, e0, a0, r0, c0;
        logic [19:0] exp_wr[$];
        logic [19:0] pend[$];
        logic [11:0] exp_rd[$];
        logic [7:0]  exp_cpl[$];
        int exp_ack, exp_err, exp_tog;
        logic [19:0] expw [4];

        // Reset state
        idle(3);
        check("reset_outputs", all_outs(), 64'h0);
        rst_n = 1'b1;
        idle(2);

        // Three uncommitted writes then a commit: four back-to-back register writes
        wr(0, 12'h123, 8'hA5);
        wr(0, 12'h124, 8'h5A);
        wr(0, 12'h125, 8'h3C);
        check("no_write_before_commit", 64'(wr_log.size()), 64'd0);
        wr(1, 12'h126, 8'h77);
        expw[0] = {12'h123, 8'hA5};
        expw[1] = {12'h124, 8'h5A};
        expw[2] = {12'h125, 8'h3C};
        expw[3] = {12'h126, 8'h77};
        check("commit_not_yet_written", 64'(reg_wr_en), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check($sformatf("flush_wr%0d", i), 64'({reg_wr_en, reg_wr_addr, reg_wr_data}),
                  64'({1'b1, expw[i]}));
        end
        check("toggle_not_early", 64'(mb_tx_ack_req_toggle), 64'd0);
        idle(1);
        check("flush_done_toggle", 64'({reg_wr_en, mb_tx_ack_req_toggle}), 64'b01);

        // Read request timing
        rd(12'hF10);
        check("rd_req_pulse", 64'({m2p_rd_req, m2p_rd_addr}), 64'({1'b1, 12'hF10}));
        idle(1);
        check("rd_req_end", 64'({m2p_rd_req, m2p_rd_addr}), 64'({1'b0, 12'hF10}));

        // Completion, write_ack and an unknown command
        send(8'h40);
        send(8'hC3);
        check("cpl_pulse", 64'({m2p_rd_cpl_valid, m2p_rd_cpl_data}), 64'({1'b1, 8'hC3}));
        send(8'h50);
        check("wr_ack_pulse", 64'({m2p_wr_ack, m2p_rd_cpl_valid, mb_rx_err}), 64'b100);
        send(8'h90);
        check("err_pulse_only", 64'({m2p_wr_ack, m2p_rd_req, m2p_rd_cpl_valid, reg_wr_en, mb_rx_err}),
              64'b00001);
        idle(2);

        // Single-frame table
        vecs[0] = '{8'h3F, 8'h10, 2, 1, 0, 0, 0, 12'hF10, 8'h00};
        vecs[1] = '{8'h40, 8'hC3, 2, 0, 1, 0, 0, 12'h000, 8'hC3};
        vecs[2] = '{8'h50, 8'h00, 1, 0, 0, 1, 0, 12'h000, 8'h00};
        vecs[3] = '{8'h90, 8'h00, 1, 0, 0, 0, 1, 12'h000, 8'h00};
        vecs[4] = '{8'h07, 8'h00, 1, 0, 0, 0, 0, 12'h000, 8'h00};
        vecs[5] = '{8'h3A, 8'h05, 2, 1, 0, 0, 0, 12'hA05, 8'h00};
        vecs[6] = '{8'hFF, 8'h00, 1, 0, 0, 0, 1, 12'h000, 8'h00};
        vecs[7] = '{8'h4E, 8'h50, 2, 0, 1, 0, 0, 12'h000, 8'h50};
        for (int i = 0; i < 8; i++) begin
            r0 = rd_log.size(); c0 = cpl_log.size(); a0 = ack_cnt; e0 = err_cnt;
            send(vecs[i].b0);
            if (vecs[i].nb == 2) send(vecs[i].b1);
            idle(3);
            check($sformatf("vec%0d_events", i),
                  64'({8'(rd_log.size() - r0), 8'(cpl_log.size() - c0), 8'(ack_cnt - a0), 8'(err_cnt - e0)}),
                  64'({8'(vecs[i].exp_rd), 8'(vecs[i].exp_cpl), 8'(vecs[i].exp_ack), 8'(vecs[i].exp_err)}));
            if (vecs[i].exp_rd == 1 && rd_log.size() > 0)
                check($sformatf("vec%0d_rd_addr", i), 64'(rd_log[$]), 64'(vecs[i].exp_addr));
            if (vecs[i].exp_cpl == 1 && cpl_log.size() > 0)
                check($sformatf("vec%0d_cpl_data", i), 64'(cpl_log[$]), 64'(vecs[i].exp_data));
        end

        // Overflow: sixth uncommitted write dropped
        wr_log.delete();
        e0 = err_cnt; t0 = tog_cnt;
        for (int i = 0; i < 6; i++) wr(0, 12'h200 + 12'(i), 8'h10 + 8'(i));
        idle(1);
        check("overflow_err", 64'(err_cnt - e0), 64'd1);
        wr(1, 12'h2FF, 8'hEE);
        idle(10);
        check("overflow_flush_count", 64'(wr_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < wr_log.size(); i++)
            check($sformatf("overflow_wr%0d", i), 64'(wr_log[i]),
                  64'((i < 5) ? {12'h200 + 12'(i), 8'h10 + 8'(i)} : {12'h2FF, 8'hEE}));
        check("overflow_one_ack", 64'(tog_cnt - t0), 64'd1);

        // Reads issued while a flush is in progress
        wr_log.delete();
        r0 = rd_log.size(); t0 = tog_cnt;
        wr(0, 12'h310, 8'h01);
        wr(0, 12'h311, 8'h02);
        wr(1, 12'h312, 8'h03);
        rd(12'h7AB);
        rd(12'h0CD);
        idle(10);
        check("flush_rd_wr_order", 64'(wr_log.size() == 3 ?
              {wr_log[0], wr_log[1], wr_log[2]} : 60'h0),
              64'({12'h310, 8'h01, 12'h311, 8'h02, 12'h312, 8'h03}));
        check("flush_rd_addrs", 64'(rd_log.size() - r0 == 2 ? {rd_log[r0], rd_log[r0+1]} : 24'h0),
              64'({12'h7AB, 12'h0CD}));
        check("flush_rd_one_ack", 64'(tog_cnt - t0), 64'd1);

        // Reset in the middle of a committed frame
        w0 = wr_log.size(); t0 = tog_cnt;
        send(8'h21);
        send(8'h55);
        rst_n = 1'b0;
        idle(2);
        check("midframe_reset_outputs", all_outs(), 64'h0);
        rst_n = 1'b1;
        idle(8);
        check("midframe_reset_no_write", 64'(wr_log.size() - w0), 64'd0);
        check("midframe_reset_no_ack", 64'(tog_cnt - t0), 64'd0);
        wr(1, 12'hABC, 8'hDE);
        idle(8);
        check("post_reset_write", 64'(wr_log.size() - w0 == 1 ? wr_log[$] : 20'h0),
              64'({12'hABC, 8'hDE}));
        check("post_reset_ack", 64'(tog_cnt - t0), 64'd1);

        // Random frame stream against a frame-level model
        idle(4);
        wr_log.delete(); rd_log.delete(); cpl_log.delete();
        a0 = ack_cnt; e0 = err_cnt; t0 = tog_cnt;
        exp_ack = 0; exp_err = 0; exp_tog = 0;
        for (int n = 0; n < 80; n++) begin
            int k;
            logic [11:0] a;
            logic [7:0]  d;
            k = int'($urandom_range(0, 9));
            a = 12'($urandom_range(0, 4095));
            d = 8'($urandom_range(0, 255));
            if (k <= 3) begin
                if (pend.size() < 5) pend.push_back({a, d});
                else exp_err++;
                wr(0, a, d);
            end else if (k == 4) begin
                foreach (pend[j]) exp_wr.push_back(pend[j]);
                exp_wr.push_back({a, d});
                pend.delete();
                exp_tog++;
                wr(1, a, d);
                idle(8);
            end else if (k == 5) begin
                exp_rd.push_back(a);
                rd(a);
            end else if (k == 6) begin
                exp_cpl.push_back(d);
                send({4'h4, a[3:0]});
                send(d);
            end else if (k == 7) begin
                exp_ack++;
                send({4'h5, a[3:0]});
            end else if (k == 8) begin
                exp_err++;
                send({4'($urandom_range(6, 15)), a[3:0]});
            end else begin
                send({4'h0, a[3:0]});
            end
        end
        idle(10);
        check("rand_wr_count", 64'(wr_log.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check($sformatf("rand_wr%0d", i), 64'(wr_log[i]), 64'(exp_wr[i]));
        check("rand_rd_count", 64'(rd_log.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            check($sformatf("rand_rd%0d", i), 64'(rd_log[i]), 64'(exp_rd[i]));
        check("rand_cpl_count", 64'(cpl_log.size()), 64'(exp_cpl.size()));
        for (int i = 0; i < exp_cpl.size() && i < cpl_log.size(); i++)
            check($sformatf("rand_cpl%0d", i), 64'(cpl_log[i]), 64'(exp_cpl[i]));
        check("rand_ack_count", 64'(ack_cnt - a0), 64'(exp_ack));
        check("rand_err_count", 64'(err_cnt - e0), 64'(exp_err));
        check("rand_toggle_count", 64'(tog_cnt - t0), 64'(exp_tog));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
